// File: rtl/pb_debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package pb_debounce_pkg;

   // Per-channel debounce FSM encoding
   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } db_state_e;

   // 10 ms at 50 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   // Short qualification window for simulation
   localparam int unsigned DEBOUNCE_CYCLES_SIM = 8;
   // DE10-Lite has two KEY pins
   localparam int unsigned WIDTH_DEF           = 2;

endpackage

// File: rtl/pushbutton_debouncer_if.sv
// Button pins in, debounced level and edge pulses out.
interface pushbutton_debouncer_if #(
   parameter int unsigned WIDTH = 2
);

   logic [WIDTH-1:0] key_n_in;
   logic [WIDTH-1:0] key_db;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;

   // Board / stimulus side
   modport master (
      output key_n_in,
      input  key_db,
      input  press_pulse,
      input  release_pulse
   );

   // Debouncer side
   modport slave (
      input  key_n_in,
      output key_db,
      output press_pulse,
      output release_pulse
   );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, qualify counter FSM, registered pulses.
module debounce_channel
   import pb_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key_n,
   output logic o_key_db,
   output logic o_press_pulse,
   output logic o_release_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   // The STABLE cycle that first sees the mismatch is the first qualifying
   // cycle, so CHANGING only needs DEBOUNCE_CYCLES-1 more; key_db then moves
   // exactly DEBOUNCE_CYCLES edges after sync_q first differs.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic             r_sync_meta;
   logic             r_sync_q;
   db_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_key_db;
   logic             r_press;
   logic             r_release;

   db_state_e        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_key_db_nxt;
   logic             w_press_nxt;
   logic             w_release_nxt;
   logic             w_mismatch;

   // Two-flop synchroniser for the asynchronous pin; resets to released
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_meta <= 1'b1;
         r_sync_q    <= 1'b1;
      end else begin
         r_sync_meta <= i_key_n;
         r_sync_q    <= r_sync_meta;
      end
   end

   assign w_mismatch = (r_sync_q != r_key_db);

   // State, counter, debounced level and pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_STABLE;
         r_cnt     <= '0;
         r_key_db  <= 1'b1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_key_db  <= w_key_db_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Qualification: any bounce back returns to STABLE with no credit kept
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = '0;
      w_key_db_nxt  = r_key_db;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         ST_STABLE: begin
            if (w_mismatch) begin
               w_state_nxt = ST_CHANGING;
            end
         end
         ST_CHANGING: begin
            if (!w_mismatch) begin
               w_state_nxt = ST_STABLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt   = ST_STABLE;
               w_key_db_nxt  = r_sync_q;
               w_press_nxt   = ~r_sync_q;
               w_release_nxt = r_sync_q;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   assign o_key_db        = r_key_db;
   assign o_press_pulse   = r_press;
   assign o_release_pulse = r_release;

endmodule

// File: rtl/pushbutton_debouncer.sv
// Debounces the raw KEY pins; key_db feeds the pushbutton PIO in_port.
module pushbutton_debouncer
   import pb_debounce_pkg::*;
#(
   parameter int unsigned WIDTH           = WIDTH_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   pushbutton_debouncer_if.slave bus
);

   // One fully independent channel per button
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk             (clk),
         .reset           (reset),
         .i_key_n         (bus.key_n_in[gi]),
         .o_key_db        (bus.key_db[gi]),
         .o_press_pulse   (bus.press_pulse[gi]),
         .o_release_pulse (bus.release_pulse[gi])
      );
   end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Self-checking bench for pushbutton_debouncer (WIDTH=2, DEBOUNCE_CYCLES=8).
module tb_pushbutton_debouncer;
   import pb_debounce_pkg::*;

   localparam int unsigned W = 2;
   localparam int unsigned D = DEBOUNCE_CYCLES_SIM;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pushbutton_debouncer_if #(.WIDTH(W)) bus ();

   pushbutton_debouncer #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   // Reference model: a level follows the 2-edge-delayed pin once that
   // delayed pin has disagreed with it for D consecutive clock edges.
   logic [W-1:0] m_h0, m_h1, m_db, m_pr, m_rl;
   int           m_run [W];
   logic         m_rst;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin : model
      logic [W-1:0] db_n, pr_n, rl_n;
      int           run_n [W];
      db_n = m_db;
      pr_n = '0;
      rl_n = '0;
      for (int i = 0; i < W; i++) run_n[i] = m_run[i];
      if (reset) begin
         db_n = '1;
         for (int i = 0; i < W; i++) run_n[i] = 0;
         m_h0 <= '1;
         m_h1 <= '1;
      end else begin
         for (int i = 0; i < W; i++) begin
            if (m_h1[i] != db_n[i]) begin
               run_n[i] = run_n[i] + 1;
               if (run_n[i] == int'(D)) begin
                  db_n[i]  = m_h1[i];
                  pr_n[i]  = ~m_h1[i];
                  rl_n[i]  = m_h1[i];
                  run_n[i] = 0;
               end
            end else begin
               run_n[i] = 0;
            end
         end
         m_h1 <= m_h0;
         m_h0 <= bus.key_n_in;
      end
      m_db    <= db_n;
      m_pr    <= pr_n;
      m_rl    <= rl_n;
      m_run   <= run_n;
      m_rst   <= reset;
      if (reset) m_valid <= 1'b1;
   end

   // Every cycle: compare against the model and check pulse invariants
   logic [W-1:0] p_db, p_pr, p_rl;
   bit           p_ok = 1'b0;

   always @(negedge clk) begin
      if (m_valid) begin
         check("model", 8'({bus.key_db, bus.press_pulse, bus.release_pulse}),
               8'({m_db, m_pr, m_rl}));
         check("pulse_excl", 8'(bus.press_pulse & bus.release_pulse), 8'd0);
         if (p_ok && !m_rst) begin
            check("pulse_width", 8'((bus.press_pulse & p_pr) | (bus.release_pulse & p_rl)), 8'd0);
            check("db_change_pulse", 8'(bus.key_db ^ p_db),
                  8'(bus.press_pulse | bus.release_pulse));
         end
      end
      p_db <= bus.key_db;
      p_pr <= bus.press_pulse;
      p_rl <= bus.release_pulse;
      p_ok <= m_valid;
   end

   typedef struct {
      logic         rst;
      logic [W-1:0] key;
      int unsigned  n;
      logic [W-1:0] db;
      logic [W-1:0] pr;
      logic [W-1:0] rl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [W-1:0] k, input int unsigned n,
                               input logic [W-1:0] db, input logic [W-1:0] pr,
                               input logic [W-1:0] rl);
      vec_t v;
      v.rst = r; v.key = k; v.n = n; v.db = db; v.pr = pr; v.rl = rl;
      return v;
   endfunction

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input logic [W-1:0] db,
                             input logic [W-1:0] pr, input logic [W-1:0] rl);
      check({name, "_db"}, 8'(bus.key_db), 8'(db));
      check({name, "_press"}, 8'(bus.press_pulse), 8'(pr));
      check({name, "_release"}, 8'(bus.release_pulse), 8'(rl));
   endtask

   int presses;

   initial begin
      reset        = 1'b1;
      bus.key_n_in = 2'b00;

      // Reset with both keys held, then release-and-qualify
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 2'b00, 1, 2'b11, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b00, 9, 2'b11, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b00, 1, 2'b00, 2'b11, 2'b00));
      vecs.push_back(mk(1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00));
      // Release both
      vecs.push_back(mk(1'b0, 2'b11, 9, 2'b00, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b11));
      vecs.push_back(mk(1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b00));
      // Clean press on ch0, ch1 untouched
      vecs.push_back(mk(1'b0, 2'b10, 9, 2'b11, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b00));
      // 7-cycle glitch on ch1: ignored
      vecs.push_back(mk(1'b0, 2'b00, 7, 2'b10, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 10, 2'b10, 2'b00, 2'b00));
      // 8-cycle low on ch1: qualifies, then release qualifies
      vecs.push_back(mk(1'b0, 2'b00, 8, 2'b10, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 2, 2'b00, 2'b10, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 7, 2'b00, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b10));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b00));
      // Simultaneous opposite transitions, both directions
      vecs.push_back(mk(1'b0, 2'b01, 9, 2'b10, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b01, 1, 2'b01, 2'b10, 2'b01));
      vecs.push_back(mk(1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 9, 2'b01, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b10));
      vecs.push_back(mk(1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b00));
      // Release ch0
      vecs.push_back(mk(1'b0, 2'b11, 9, 2'b10, 2'b00, 2'b00));
      vecs.push_back(mk(1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b01));
      vecs.push_back(mk(1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b00));

      foreach (vecs[i]) begin
         reset        = vecs[i].rst;
         bus.key_n_in = vecs[i].key;
         step(vecs[i].n);
         check_outs($sformatf("vec%0d", i), vecs[i].db, vecs[i].pr, vecs[i].rl);
      end

      // Bouncy press on ch0: toggles every 3 cycles for 24 cycles, then held low
      presses = 0;
      for (int seg = 0; seg < 8; seg++) begin
         bus.key_n_in = {1'b1, 1'(seg % 2)};
         for (int c = 0; c < 3; c++) begin
            step(1);
            if (bus.press_pulse[0]) presses++;
            check("bounce_hold", 8'(bus.key_db), 8'(2'b11));
         end
      end
      bus.key_n_in = 2'b10;
      for (int k = 1; k <= 11; k++) begin
         step(1);
         if (bus.press_pulse[0]) presses++;
         if (k < 10)       check("bounce_wait", 8'(bus.key_db), 8'(2'b11));
         else if (k == 10) check_outs("bounce_fall", 2'b10, 2'b01, 2'b00);
         else              check("bounce_after", 8'(bus.key_db), 8'(2'b10));
      end
      check("bounce_presses", 8'(presses), 8'd1);

      // Release ch0, then reset while the press is mid-qualification (cnt=5)
      bus.key_n_in = 2'b11;
      step(12);
      check_outs("rst_pre", 2'b11, 2'b00, 2'b00);
      bus.key_n_in = 2'b10;
      step(8);
      check_outs("rst_cnt5", 2'b11, 2'b00, 2'b00);
      reset = 1'b1;
      step(1);
      check_outs("rst_edge", 2'b11, 2'b00, 2'b00);
      step(1);
      check_outs("rst_hold", 2'b11, 2'b00, 2'b00);
      reset = 1'b0;
      step(9);
      check_outs("rst_requal_wait", 2'b11, 2'b00, 2'b00);
      step(1);
      check_outs("rst_requal", 2'b10, 2'b01, 2'b00);
      step(1);
      check_outs("rst_requal_after", 2'b10, 2'b00, 2'b00);

      // Random pin activity with occasional resets, checked against the model
      for (int s = 0; s < 200; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            step(1);
            reset = 1'b0;
         end
         bus.key_n_in = 2'($urandom);
         step($urandom_range(1, 14));
      end
      bus.key_n_in = 2'b11;
      step(D + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
